// File: rtl/runner_pkg.sv
// rtl/runner_pkg.sv - shared state encoding and width defaults for prog_runner
package runner_pkg;

  localparam int DEF_PC_W  = 8;
  localparam int DEF_SEL_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } run_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - registered rising-edge detector with programmable history reset value
module edge_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
    end else begin
      prev_q <= d_i;
      rise_q <= d_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/prog_runner.sv
// rtl/prog_runner.sv - launches a core at a selected program base and watches for halt or budget expiry
module prog_runner
  import runner_pkg::*;
#(
  parameter int                          PC_W       = DEF_PC_W,
  parameter int                          NUM_PROGS  = 4,
  parameter logic [NUM_PROGS*PC_W-1:0]   PROG_BASE  = {8'h60, 8'h40, 8'h20, 8'h00},
  parameter logic [PC_W-1:0]             HALT_PC    = '1,
  parameter int                          CNT_W      = 16,
  parameter int                          MAX_CYCLES = 4096,
  localparam int                         SEL_W      = sel_width(NUM_PROGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] prog_sel,
  input  logic             abort,
  input  logic [PC_W-1:0]  core_pc,
  output logic             core_rst,
  output logic [PC_W-1:0]  core_pc_init,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  run_state_e       state_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic [CNT_W-1:0] cycle_count_d;
  logic [PC_W-1:0]  pc_init_q;
  logic [SEL_W-1:0] sel_dly_q;
  logic [PC_W-1:0]  slot_base;
  logic             start_rise;

  // The edge detector output lags start by one cycle; delaying prog_sel the
  // same amount keeps the slot aligned with the start sample that caused it.
  edge_det #(
    .RESET_VAL (1'b1)
  ) u_start_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (start),
    .rise_o (start_rise)
  );

  always_comb begin
    slot_base = PROG_BASE[PC_W-1:0];
    for (int i = 1; i < NUM_PROGS; i++) begin
      if (sel_dly_q == SEL_W'(i)) slot_base = PROG_BASE[i*PC_W +: PC_W];
    end
  end

  assign cycle_count_d = cycle_count_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cycle_count_q <= '0;
      pc_init_q     <= PROG_BASE[PC_W-1:0];
      sel_dly_q     <= '0;
    end else begin
      sel_dly_q <= prog_sel;
      case (state_q)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          if (start_rise) begin
            state_q       <= ST_LAUNCH;
            pc_init_q     <= slot_base;
            cycle_count_q <= '0;
          end
        end
        ST_LAUNCH: state_q <= abort ? ST_IDLE : ST_RUN;
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (core_pc == HALT_PC) begin
            state_q <= ST_DONE;
          end else begin
            cycle_count_q <= cycle_count_d;
            if (cycle_count_d == CNT_W'(MAX_CYCLES)) state_q <= ST_TIMEOUT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_rst     = (state_q != ST_RUN);
  assign core_pc_init = pc_init_q;
  assign busy         = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
  assign done         = (state_q == ST_DONE);
  assign timeout      = (state_q == ST_TIMEOUT);
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_prog_runner.sv
// tb/tb_prog_runner.sv - scoreboard bench for prog_runner run outcomes, timing and reset behaviour
module tb_prog_runner;

  localparam int T_MAX = 16;

  typedef struct {
    string       tag;
    logic [7:0]  init;
    logic        done;
    logic        to;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b1;
  logic [1:0]  prog_sel = '0;
  logic        abort = 1'b0;
  logic [7:0]  core_pc = 8'h10;
  logic        core_rst;
  logic [7:0]  core_pc_init;
  logic        busy, done, timeout;
  logic [15:0] cycle_count;

  logic        start3 = 1'b0;
  logic [1:0]  prog_sel3 = '0;
  logic        abort3 = 1'b0;
  logic        core_rst3;
  logic [7:0]  core_pc_init3;
  logic        busy3, done3, timeout3;
  logic [15:0] cycle_count3;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;

  prog_runner #(
    .PC_W(8), .NUM_PROGS(4), .PROG_BASE(32'h6040_2000), .HALT_PC(8'hFF),
    .CNT_W(16), .MAX_CYCLES(T_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .prog_sel(prog_sel), .abort(abort),
    .core_pc(core_pc), .core_rst(core_rst), .core_pc_init(core_pc_init),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  prog_runner #(
    .PC_W(8), .NUM_PROGS(3), .PROG_BASE(24'h40_2000), .HALT_PC(8'hFF),
    .CNT_W(16), .MAX_CYCLES(T_MAX)
  ) dut3 (
    .clk(clk), .rst(rst), .start(start3), .prog_sel(prog_sel3), .abort(abort3),
    .core_pc(core_pc), .core_rst(core_rst3), .core_pc_init(core_pc_init3),
    .busy(busy3), .done(done3), .timeout(timeout3), .cycle_count(cycle_count3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (busy_prev && !busy && !rst) begin
      check("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, "_done"},    32'(done),         32'(e.done));
        check({e.tag, "_timeout"}, 32'(timeout),      32'(e.to));
        check({e.tag, "_count"},   32'(cycle_count),  32'(e.cnt));
        check({e.tag, "_init"},    32'(core_pc_init), 32'(e.init));
        check({e.tag, "_core_rst"}, 32'(core_rst),    32'd1);
      end
    end
    busy_prev <= busy;
  end

  task automatic run(input string tag, input int sel, input int halt_j, input int abort_j,
                     input int rst_j, input bit hold, input logic [7:0] e_init,
                     input logic e_done, input logic e_to, input logic [15:0] e_cnt);
    exp_t e;
    if (rst_j == 0) begin
      e.tag = tag; e.init = e_init; e.done = e_done; e.to = e_to; e.cnt = e_cnt;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b1; prog_sel = 2'(sel); core_pc = 8'h10;
    @(negedge clk);
    check({tag, "_pre"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_launch"}, 32'({busy, core_rst, done, timeout}), 32'b1100);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      check({tag, "_run"}, 32'({busy, core_rst, timeout}), 32'b100);
      if (j == rst_j) begin
        #1 rst = 1'b1;
        #1;
        check({tag, "_rst_ctl"}, 32'({busy, core_rst, done, timeout}), 32'b0100);
        check({tag, "_rst_cnt"}, 32'(cycle_count), 32'd0);
        check({tag, "_rst_init"}, 32'(core_pc_init), 32'h00);
        @(negedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        return;
      end
      core_pc = (j == halt_j) ? 8'hFF : 8'(8'h10 + j);
      abort = (j == abort_j);
      if (j == halt_j || j == abort_j || j == T_MAX) break;
    end
    @(negedge clk);
    abort = 1'b0; core_pc = 8'h10;
    if (hold) begin
      repeat (4) begin
        @(negedge clk);
        check({tag, "_hold"}, 32'(busy), 32'd0);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_ctl", 32'({busy, core_rst, done, timeout}), 32'b0100);
    check("reset_cnt", 32'(cycle_count), 32'd0);
    check("reset_init", 32'(core_pc_init), 32'h00);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("start_held_rst", 32'(busy), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);

    run("halt",    2, 11,  0, 0, 1'b0, 8'h40, 1'b1, 1'b0, 16'd10);
    run("budget",  1,  0,  0, 0, 1'b0, 8'h20, 1'b0, 1'b1, 16'd16);
    run("tie",     3, 16,  0, 0, 1'b0, 8'h60, 1'b1, 1'b0, 16'd15);
    run("abort",   0,  0,  5, 0, 1'b1, 8'h00, 1'b0, 1'b0, 16'd4);
    run("rerun",   2,  4,  0, 0, 1'b0, 8'h40, 1'b1, 1'b0, 16'd3);
    run("midrst",  3,  0,  0, 3, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
    check("post_rst_idle", 32'({busy, done, timeout}), 32'b000);

    @(negedge clk);
    start3 = 1'b1; prog_sel3 = 2'd1;
    repeat (2) @(negedge clk);
    check("n3_slot1", 32'(core_pc_init3), 32'h20);
    check("n3_busy", 32'(busy3), 32'd1);
    abort3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0; start3 = 1'b0;
    check("n3_abort", 32'(busy3), 32'd0);
    @(negedge clk);
    start3 = 1'b1; prog_sel3 = 2'd3;
    repeat (2) @(negedge clk);
    check("n3_oob_slot", 32'(core_pc_init3), 32'h00);
    abort3 = 1'b1;
    @(negedge clk);
    abort3 = 1'b0; start3 = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
